// File: rtl/counter_pkg.sv
// Shared types and default sizes for the multimode counter and its prescaler.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_PRESC_W = 4;

endpackage

// File: rtl/counter_prescaler.sv
// Programmable divider: tick fires once every presc_div+1 enabled cycles.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc_div,
  input  logic               clr,
  output logic               tick
);

  logic [PRESC_W-1:0] presc_cnt_q;
  logic [PRESC_W-1:0] presc_cnt_d;

  // Only an exact match ticks, so a divider lowered below the current
  // phase lets the count run round its whole range first.
  assign tick = en && (presc_cnt_q == presc_div);

  always_comb begin
    presc_cnt_d = presc_cnt_q;
    if (clr) begin
      presc_cnt_d = '0;
    end else if (en) begin
      presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt_q <= '0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
    end
  end

endmodule

// File: rtl/counter_multimode.sv
// Up/down/bounce/hold counter with modulo limit, parallel load, prescaler and tc pulse.
// Optional snapshot register enabled by defining COUNTER_CAPTURE_EN.
module counter_multimode
  import counter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [WIDTH-1:0]   modulo,
  input  logic [PRESC_W-1:0] presc_div,
  input  logic               capture,
  output logic [WIDTH-1:0]   count,
  output logic               dir,
  output logic               tc,
  output logic [WIDTH-1:0]   cap_val
);

  mode_e            mode_s;
  logic             active;
  logic             tick;
  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             tc_q, tc_d;

  assign mode_s = mode_e'(mode);
  assign active = en && (mode_s != MODE_HOLD);

  counter_prescaler #(
    .PRESC_W(PRESC_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (active),
    .presc_div(presc_div),
    .clr      (load),
    .tick     (tick)
  );

  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    tc_d    = 1'b0;
    if (load) begin
      count_d = load_val;
    end else begin
      case (mode_s)
        MODE_UP: begin
          dir_d = 1'b0;
          if (tick) begin
            if (count_q >= modulo) begin
              count_d = '0;
              tc_d    = 1'b1;
            end else begin
              count_d = count_q + WIDTH'(1);
            end
          end
        end
        MODE_DOWN: begin
          dir_d = 1'b1;
          if (tick) begin
            if (count_q == '0) begin
              count_d = modulo;
              tc_d    = 1'b1;
            end else begin
              count_d = count_q - WIDTH'(1);
            end
          end
        end
        MODE_BOUNCE: begin
          // A zero modulo pins count at 0; each step then only flips dir.
          if (tick) begin
            if (!dir_q) begin
              if (count_q >= modulo) begin
                dir_d   = 1'b1;
                tc_d    = 1'b1;
                count_d = (modulo == '0) ? '0 : modulo - WIDTH'(1);
              end else begin
                count_d = count_q + WIDTH'(1);
              end
            end else begin
              if (count_q == '0) begin
                dir_d   = 1'b0;
                tc_d    = 1'b1;
                count_d = (modulo == '0) ? '0 : WIDTH'(1);
              end else begin
                count_d = count_q - WIDTH'(1);
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      dir_q   <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign dir   = dir_q;
  assign tc    = tc_q;

`ifdef COUNTER_CAPTURE_EN
  logic [WIDTH-1:0] cap_val_q, cap_val_d;

  always_comb begin
    cap_val_d = cap_val_q;
    if (capture) begin
      cap_val_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_val_q <= '0;
    end else begin
      cap_val_q <= cap_val_d;
    end
  end

  assign cap_val = cap_val_q;
`else
  logic unused_capture;
  assign unused_capture = capture;
  assign cap_val        = '0;
`endif

endmodule

// File: tb/tb_counter_multimode.sv
// Directed self-checking bench for counter_multimode (default WIDTH=8, PRESC_W=4).
module tb_counter_multimode;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] modulo;
  logic [3:0] presc_div;
  logic       capture;
  logic [7:0] count;
  logic       dir;
  logic       tc;
  logic [7:0] cap_val;

  int n_cmp = 0;
  int n_err = 0;

`ifdef COUNTER_CAPTURE_EN
  localparam bit CAP_EN = 1'b1;
`else
  localparam bit CAP_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  counter_multimode dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .modulo   (modulo),
    .presc_div(presc_div),
    .capture  (capture),
    .count    (count),
    .dir      (dir),
    .tc       (tc),
    .cap_val  (cap_val)
  );

  task automatic edge_n(input int n);
    repeat (n) @(posedge clk);
    #1;
    $display("t=%0t count=%0h dir=%0b tc=%0b cap_val=%0h", $time, count, dir, tc, cap_val);
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; mode = 2'b00; modulo = 8'd5; presc_div = 4'd0;
    edge_n(1);
    n_cmp++; if (count !== 8'd0) begin n_err++; $display("FAIL reset_count got=%0h exp=0", count); end
    n_cmp++; if (dir !== 1'b0) begin n_err++; $display("FAIL reset_dir got=%0b exp=0", dir); end
    n_cmp++; if (tc !== 1'b0) begin n_err++; $display("FAIL reset_tc got=%0b exp=0", tc); end
    n_cmp++; if (cap_val !== 8'd0) begin n_err++; $display("FAIL reset_cap got=%0h exp=0", cap_val); end
    rst = 1'b0;
    edge_n(3);
    n_cmp++; if (count !== 8'd3) begin n_err++; $display("FAIL pre_reset_count got=%0h exp=3", count); end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      edge_n(1);
      n_cmp++; if (count !== 8'd0) begin n_err++; $display("FAIL rst_mid_count[%0d] got=%0h exp=0", i, count); end
      n_cmp++; if (dir !== 1'b0 || tc !== 1'b0) begin n_err++; $display("FAIL rst_mid_dirtc[%0d] got=%0b%0b exp=00", i, dir, tc); end
      n_cmp++; if (cap_val !== 8'd0) begin n_err++; $display("FAIL rst_mid_cap[%0d] got=%0h exp=0", i, cap_val); end
    end
  endtask

  task automatic test_up_wrap;
    logic [7:0] exp_c [7] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1};
    logic       exp_t [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    rst = 1'b0; en = 1'b1; mode = 2'b00; modulo = 8'd5; presc_div = 4'd0;
    for (int i = 0; i < 7; i++) begin
      edge_n(1);
      n_cmp++; if (count !== exp_c[i]) begin n_err++; $display("FAIL up_count[%0d] got=%0h exp=%0h", i, count, exp_c[i]); end
      n_cmp++; if (tc !== exp_t[i]) begin n_err++; $display("FAIL up_tc[%0d] got=%0b exp=%0b", i, tc, exp_t[i]); end
      n_cmp++; if (dir !== 1'b0) begin n_err++; $display("FAIL up_dir[%0d] got=%0b exp=0", i, dir); end
    end
  endtask

  task automatic test_presc_down;
    logic [7:0] exp_c [9] = '{8'd2, 8'd2, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd3};
    logic       exp_t [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    load = 1'b1; load_val = 8'd2; presc_div = 4'd2; modulo = 8'd3; mode = 2'b01; en = 1'b1;
    edge_n(1);
    n_cmp++; if (count !== 8'd2) begin n_err++; $display("FAIL pd_load_count got=%0h exp=2", count); end
    n_cmp++; if (dir !== 1'b0) begin n_err++; $display("FAIL pd_load_dir got=%0b exp=0", dir); end
    load = 1'b0;
    for (int i = 0; i < 9; i++) begin
      edge_n(1);
      n_cmp++; if (count !== exp_c[i]) begin n_err++; $display("FAIL pd_count[%0d] got=%0h exp=%0h", i, count, exp_c[i]); end
      n_cmp++; if (tc !== exp_t[i]) begin n_err++; $display("FAIL pd_tc[%0d] got=%0b exp=%0b", i, tc, exp_t[i]); end
      n_cmp++; if (dir !== 1'b1) begin n_err++; $display("FAIL pd_dir[%0d] got=%0b exp=1", i, dir); end
    end
    edge_n(1);
    n_cmp++; if (count !== 8'd3 || tc !== 1'b0) begin n_err++; $display("FAIL pd_after_wrap got=%0h/%0b exp=3/0", count, tc); end
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      edge_n(1);
      n_cmp++; if (count !== 8'd3 || tc !== 1'b0) begin n_err++; $display("FAIL pd_frozen[%0d] got=%0h/%0b exp=3/0", i, count, tc); end
    end
    en = 1'b1;
    edge_n(1);
    n_cmp++; if (count !== 8'd3) begin n_err++; $display("FAIL pd_phase_a got=%0h exp=3", count); end
    edge_n(1);
    n_cmp++; if (count !== 8'd2) begin n_err++; $display("FAIL pd_phase_b got=%0h exp=2", count); end
  endtask

  task automatic test_bounce;
    logic [7:0] exp_c [8] = '{8'd1, 8'd2, 8'd3, 8'd2, 8'd1, 8'd0, 8'd1, 8'd2};
    logic       exp_d [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       exp_t [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    mode = 2'b00; en = 1'b0; presc_div = 4'd0;
    edge_n(1);
    n_cmp++; if (dir !== 1'b0 || count !== 8'd2) begin n_err++; $display("FAIL bn_dir_force got=%0b/%0h exp=0/2", dir, count); end
    load = 1'b1; load_val = 8'd0; mode = 2'b10; en = 1'b1; modulo = 8'd3;
    edge_n(1);
    n_cmp++; if (count !== 8'd0 || dir !== 1'b0) begin n_err++; $display("FAIL bn_load got=%0h/%0b exp=0/0", count, dir); end
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      edge_n(1);
      n_cmp++; if (count !== exp_c[i]) begin n_err++; $display("FAIL bn_count[%0d] got=%0h exp=%0h", i, count, exp_c[i]); end
      n_cmp++; if (dir !== exp_d[i]) begin n_err++; $display("FAIL bn_dir[%0d] got=%0b exp=%0b", i, dir, exp_d[i]); end
      n_cmp++; if (tc !== exp_t[i]) begin n_err++; $display("FAIL bn_tc[%0d] got=%0b exp=%0b", i, tc, exp_t[i]); end
    end
    modulo = 8'd0; load = 1'b1; load_val = 8'd0;
    edge_n(1);
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      edge_n(1);
      n_cmp++; if (count !== 8'd0) begin n_err++; $display("FAIL bn0_count[%0d] got=%0h exp=0", i, count); end
      n_cmp++; if (dir !== ((i % 2) == 0)) begin n_err++; $display("FAIL bn0_dir[%0d] got=%0b exp=%0b", i, dir, (i % 2) == 0); end
      n_cmp++; if (tc !== 1'b1) begin n_err++; $display("FAIL bn0_tc[%0d] got=%0b exp=1", i, tc); end
    end
  endtask

  task automatic test_load_priority;
    mode = 2'b00; modulo = 8'h10; presc_div = 4'd0; en = 1'b1; load = 1'b1; load_val = 8'hF0;
    edge_n(1);
    n_cmp++; if (count !== 8'hF0) begin n_err++; $display("FAIL lp_count got=%0h exp=f0", count); end
    n_cmp++; if (tc !== 1'b0) begin n_err++; $display("FAIL lp_tc got=%0b exp=0", tc); end
    load = 1'b0;
    edge_n(1);
    n_cmp++; if (count !== 8'h00 || tc !== 1'b1) begin n_err++; $display("FAIL lp_wrap got=%0h/%0b exp=0/1", count, tc); end
    edge_n(1);
    n_cmp++; if (count !== 8'h01 || tc !== 1'b0) begin n_err++; $display("FAIL lp_next got=%0h/%0b exp=1/0", count, tc); end
    mode = 2'b11;
    for (int i = 0; i < 10; i++) begin
      edge_n(1);
      n_cmp++; if (count !== 8'h01 || tc !== 1'b0 || dir !== 1'b0) begin
        n_err++; $display("FAIL hold[%0d] got=%0h/%0b/%0b exp=1/0/0", i, count, tc, dir);
      end
    end
    mode = 2'b00;
    edge_n(1);
    n_cmp++; if (count !== 8'h02) begin n_err++; $display("FAIL hold_resume got=%0h exp=2", count); end
  endtask

  task automatic test_tc_continuous;
    modulo = 8'd0; mode = 2'b00; presc_div = 4'd0; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      edge_n(1);
      n_cmp++; if (count !== 8'd0 || tc !== 1'b1) begin n_err++; $display("FAIL tc_cont[%0d] got=%0h/%0b exp=0/1", i, count, tc); end
    end
  endtask

  task automatic test_full_range;
    modulo = 8'hFF; load = 1'b1; load_val = 8'hFE; mode = 2'b00; en = 1'b1;
    edge_n(1);
    load = 1'b0;
    edge_n(1);
    n_cmp++; if (count !== 8'hFF || tc !== 1'b0) begin n_err++; $display("FAIL fr_top got=%0h/%0b exp=ff/0", count, tc); end
    edge_n(1);
    n_cmp++; if (count !== 8'h00 || tc !== 1'b1) begin n_err++; $display("FAIL fr_wrap got=%0h/%0b exp=0/1", count, tc); end
    edge_n(1);
    n_cmp++; if (count !== 8'h01 || tc !== 1'b0) begin n_err++; $display("FAIL fr_after got=%0h/%0b exp=1/0", count, tc); end
  endtask

  task automatic test_capture;
    modulo = 8'hFF; load = 1'b1; load_val = 8'd7; mode = 2'b00; en = 1'b1;
    edge_n(1);
    load = 1'b0; capture = 1'b1;
    edge_n(1);
    n_cmp++; if (count !== 8'd8) begin n_err++; $display("FAIL cap_count got=%0h exp=8", count); end
    n_cmp++; if (cap_val !== (CAP_EN ? 8'd7 : 8'd0)) begin n_err++; $display("FAIL cap_val got=%0h exp=%0h", cap_val, CAP_EN ? 8'd7 : 8'd0); end
    capture = 1'b0;
    edge_n(1);
    n_cmp++; if (count !== 8'd9 || cap_val !== (CAP_EN ? 8'd7 : 8'd0)) begin
      n_err++; $display("FAIL cap_hold got=%0h/%0h exp=9/%0h", count, cap_val, CAP_EN ? 8'd7 : 8'd0);
    end
    en = 1'b0; capture = 1'b1;
    edge_n(1);
    n_cmp++; if (count !== 8'd9 || cap_val !== (CAP_EN ? 8'd9 : 8'd0)) begin
      n_err++; $display("FAIL cap_noen got=%0h/%0h exp=9/%0h", count, cap_val, CAP_EN ? 8'd9 : 8'd0);
    end
    capture = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; load = 1'b0; load_val = 8'd0;
    modulo = 8'd0; presc_div = 4'd0; capture = 1'b0;
    test_reset;
    test_up_wrap;
    test_presc_down;
    test_bounce;
    test_load_priority;
    test_tc_continuous;
    test_full_range;
    test_capture;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/counter_multimode.md
Name: counter_multimode

Overview:
Parametrised successor to the team's single-mode free-running counter. Provides up, down, bounce (up/down) and hold modes, a programmable modulo limit, a synchronous parallel load, a programmable prescaler, and a registered terminal-count pulse. It is instantiated inside the tt_um top, which drives it from ui_in/uio_in and shows count on uo_out.

Parameters:
WIDTH, 8, counter and modulo/load width in bits (>=2)
PRESC_W, 4, prescaler divider width in bits (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
en  input  1  count enable; gates prescaler and stepping
mode  input  2  00 up, 01 down, 10 bounce, 11 hold
load  input  1  synchronous load strobe
load_val  input  WIDTH  value loaded when load=1
modulo  input  WIDTH  upper count limit (inclusive)
presc_div  input  PRESC_W  step every presc_div+1 enabled cycles
capture  input  1  snapshot strobe (optional feature)
count  output  WIDTH  current count, registered
dir  output  1  0 = counting up, 1 = counting down, registered
tc  output  1  one-cycle terminal-count pulse, registered
cap_val  output  WIDTH  captured count (optional feature)

Behaviour:
- Reset (rst=1 at an edge): count=0, dir=0, tc=0, prescaler count=0, cap_val=0. rst overrides every other input.
- Priority per edge: rst > load > step (en & tick) > hold.
- Prescaler: internal presc_cnt advances only while en=1 and mode!=11. tick=1 when presc_cnt==presc_div, and presc_cnt returns to 0 on that edge. presc_div=0 gives a tick on every enabled cycle. If presc_div is lowered below presc_cnt, the counter wraps through its full range before the next tick.
- load: count<=load_val, presc_cnt<=0, tc<=0. dir is unchanged. load_val>modulo is allowed; the next up-step then wraps.
- Up mode (00): dir<=0. On step: if count>=modulo, count<=0 and tc pulses; else count+1.
- Down mode (01): dir<=1. On step: if count==0, count<=modulo and tc pulses; else count-1.
- Bounce mode (10): dir keeps its current value.
  - Up-step with count>=modulo: dir<=1, count<=modulo-1, tc pulses.
  - Down-step with count==0: dir<=0, count<=1, tc pulses.
  - If modulo==0, count stays 0, dir toggles and tc pulses on every step.
- Hold mode (11): count, dir and presc_cnt are frozen, and tc is 0.
- tc is high for exactly the one cycle after the wrap or turnaround edge. With presc_div=0 and modulo=0 in up mode, tc stays high continuously.
- Mode changes take effect at the next edge. Leaving bounce forces dir to the value the new mode requires.
- Arithmetic is unsigned and WIDTH bits wide with no overflow beyond modulo. modulo=2^WIDTH-1 gives full-range wrap.
- Latency: count reflects a step or load one edge after the triggering inputs are sampled.

Optional Feature:
COUNTER_CAPTURE_EN
- Defined: on an edge with capture=1, cap_val<=count, using the pre-update value. Capture is independent of en and mode.
- Undefined: capture is ignored, cap_val is tied to 0 and no capture register is synthesised. The port list is the same in both builds.

Decomposition:
- Package counter_pkg holds typedef enum logic[1:0] mode_e (MODE_UP, MODE_DOWN, MODE_BOUNCE, MODE_HOLD) and the default width constants.
- Sub-module counter_prescaler (inputs clk, rst, en, presc_div, clr; output tick) contains the divider.
- The step, wrap and direction logic stays in counter_multimode.

Test Plan:
- Reset: assert rst for 2 cycles during counting -> count=0, dir=0, tc=0, cap_val=0 on the next edge.
- Up wrap: WIDTH=8, modulo=5, presc_div=0, en=1, mode=00 -> count 0,1,2,3,4,5,0. tc is high for one cycle, in the cycle count reads 0.
- Prescaler + down: presc_div=2, modulo=3, mode=01, load 2 -> count steps every 3 cycles: 2,1,0,3. tc pulses after the 0->3 wrap. en=0 for 4 cycles freezes both count and phase.
- Bounce: modulo=3, mode=10 from 0 -> 0,1,2,3,2,1,0,1. dir flips at 3 and at 0, with a tc pulse at each turn. With modulo=0, count stays 0, dir toggles every step and tc pulses every step.
- Load priority: load=1 with load_val=8'hF0 at the same edge as a step with modulo=8'h10 -> count=F0, tc=0. The next up-step gives count=0 with a tc pulse. Hold mode then freezes count for 10 cycles.
- Capture (COUNTER_CAPTURE_EN): capture at count=7 while stepping -> cap_val=7, count=8. Without the macro, cap_val stays 0.
